// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: multi-cycle unsigned MULTU/DIVU unit for the EX stage.
// It owns the architectural HI/LO registers and holds the pipeline through
// stall while an operation iterates, one bit per cycle.
module ex_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic               start;
  logic               last;
  logic               op_div;
  logic [CW-1:0]      count;
  // Multiplicand for MULTU, divisor for DIVU.
  logic [WIDTH-1:0]   operand;
  // Upper half: partial product / remainder. Lower half: multiplier bits
  // still to consume (MULTU) or dividend bits shifting out as quotient
  // bits shift in (DIVU).
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;

  // Accept decode; reset dominates flush, flush dominates the request.
  always_comb begin
    start = !reset && !flush && in_valid && (in_op == 2'b01 || in_op == 2'b10);
    last  = (count == CW'(WIDTH - 1));
    stall = !reset && (((state == IDLE) && start) || (state == BUSY));
  end

  // One shift-add or restoring-division iteration on the accumulator.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_ge    = (div_shift >= {1'b0, operand});
    div_diff  = div_shift[WIDTH-1:0] - operand;
    if (op_div) begin
      acc_step = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
    end else begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = BUSY;
      BUSY: begin
        if (flush)     state_next = IDLE;
        else if (last) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register with registered busy/done flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == BUSY);
      done  <= (state == BUSY) && !flush && last;
    end
  end

  // Operand capture, iteration datapath and HI/LO write-back.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_div  <= 1'b0;
      operand <= '0;
      acc     <= '0;
      count   <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_div  <= (in_op == 2'b10);
            operand <= (in_op == 2'b10) ? in_b : in_a;
            acc     <= {{WIDTH{1'b0}}, ((in_op == 2'b10) ? in_a : in_b)};
            count   <= '0;
          end
        end
        BUSY: begin
          if (!flush) begin
            acc   <= acc_step;
            count <= count + 1'b1;
            if (last) begin
              hi <= acc_step[2*WIDTH-1:WIDTH];
              lo <= acc_step[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit with hand-computed results.
module tb_ex_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [1:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int passes = 0;
  int done_pulses = 0;

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .flush(flush), .stall(stall), .busy(busy),
    .done(done), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (done === 1'b1) done_pulses++;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", name, obs, exp);
  endtask

  // Issue one op in IDLE, hold the instruction in ID/EX while stalled,
  // verify stall length, the DONE cycle, then return to IDLE.
  task automatic run_op(input string name, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc = 0;
    int pulses0 = done_pulses;
    reset = 1'b0;
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    #1;
    check({name, ".stall0"}, 64'(stall), 64'd1);
    while (stall === 1'b1 && cyc < 100) begin
      cyc++;
      tick();
      in_a = 32'hDEAD_BEEF;
      in_b = 32'h0BAD_F00D;
      if (cyc == 1) check({name, ".busy1"}, 64'(busy), 64'd1);
    end
    check({name, ".stall_cycles"}, 64'(cyc), 64'd33);
    check({name, ".done"}, 64'(done), 64'd1);
    check({name, ".stall_in_done"}, 64'(stall), 64'd0);
    check({name, ".hi"}, 64'(hi), 64'(exp_hi));
    check({name, ".lo"}, 64'(lo), 64'(exp_lo));
    in_valid = 1'b0;
    tick();
    check({name, ".done_clear"}, 64'(done), 64'd0);
    check({name, ".busy_idle"}, 64'(busy), 64'd0);
    check({name, ".one_pulse"}, 64'(done_pulses - pulses0), 64'd1);
  endtask

  initial begin
    int pulses0;
    reset = 1'b1;
    in_valid = 1'b1;
    in_op = 2'b01;
    in_a = 32'd2;
    in_b = 32'd3;
    flush = 1'b0;
    tick();
    tick();
    check("rst.hi", 64'(hi), 64'd0);
    check("rst.lo", 64'(lo), 64'd0);
    check("rst.stall", 64'(stall), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);

    // Start on the first cycle after reset release.
    run_op("post_rst_mul", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6);

    run_op("mul_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div_100_7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div_msb_1", 2'b10, 32'h8000_0000, 32'd1, 32'd0, 32'h8000_0000);
    run_op("div_by_0", 2'b10, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF);
    run_op("mul_3_5", 2'b01, 32'd3, 32'd5, 32'd0, 32'd15);

    // Flush DIVU 9/2 in BUSY cycle 10.
    pulses0 = done_pulses;
    in_valid = 1'b1;
    in_op = 2'b10;
    in_a = 32'd9;
    in_b = 32'd2;
    #1;
    check("flush.stall0", 64'(stall), 64'd1);
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    check("flush.busy_c10", 64'(busy), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush.busy", 64'(busy), 64'd0);
    check("flush.stall", 64'(stall), 64'd0);
    check("flush.done", 64'(done), 64'd0);
    check("flush.hi", 64'(hi), 64'd0);
    check("flush.lo", 64'(lo), 64'd15);
    for (int i = 0; i < 40; i++) tick();
    check("flush.no_pulse", 64'(done_pulses - pulses0), 64'd0);
    check("flush.lo_later", 64'(lo), 64'd15);

    // Not valid: no start.
    in_valid = 1'b0;
    in_op = 2'b01;
    in_a = 32'd7;
    in_b = 32'd7;
    #1;
    check("novalid.stall", 64'(stall), 64'd0);
    tick();
    check("novalid.busy", 64'(busy), 64'd0);

    // Reserved op: no start.
    in_valid = 1'b1;
    in_op = 2'b11;
    #1;
    check("op11.stall", 64'(stall), 64'd0);
    tick();
    check("op11.busy", 64'(busy), 64'd0);
    check("op11.lo", 64'(lo), 64'd15);
    in_valid = 1'b0;

    // Back-to-back MULTUs.
    run_op("b2b_a", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6);
    run_op("b2b_b", 2'b01, 32'd4, 32'd5, 32'd0, 32'd20);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
